uart_autobaud: RTL and testbench
================================

// Module: uart_autobaud
// PURPOSE
//  Measures the bit period of an incoming UART sync character 0x55 on rx.
//  Returns the divisor word brd to load into the divide-by-N baud generator.
//  brd uses the generator's 25.7 fixed-point format:
//    generator half-period = brd/128 clocks; generator output = 2^OS_LOG2 x bit rate.
//  Sits between the rx pad and the baud generator's BRD input.
// PARAMETERS
//  OS_LOG2      4         log2 of oversample ratio; brd = (N << 3) >> OS_LOG2
//  MIN_CNT      64        smallest legal N (clocks over 8 bit times); smaller -> error
//  MAX_CNT      1048575   timeout; counter reaching MAX_CNT before edge 5 -> error
//  BRD_DEFAULT  32'd1736  brd reset value (115200 baud @ 50 MHz, OS_LOG2=4)
// PORTS
//  clock  in   1   system clock, all logic on posedge
//  reset  in   1   synchronous, active-low reset
//  rx     in   1   asynchronous serial line, idle high
//  start  in   1   one-cycle arm request; ignored while busy
//  busy   out  1   high from accepted start until valid/error/abort
//  valid  out  1   one-cycle pulse: brd updated with a new measurement
//  error  out  1   one-cycle pulse: measurement rejected, brd unchanged
//  brd    out  32  divisor word; holds last good value
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, busy=0, valid=0, error=0.
//   Also: brd=BRD_DEFAULT, counters=0, rx synchroniser flops=1.
//  rx passes a 2-flop synchroniser; fall = sync_q1 & ~sync_q0, rise = ~sync_q1 & sync_q0.
//  Same delay on every edge, so N is unaffected.
//  FSM:
//   IDLE  : start=1 -> ARM, busy<=1.
//   ARM   : wait for synced rx==1, then -> HUNT. Rejects arming mid-character.
//   HUNT  : fall -> MEAS; cnt<=1, fcount<=1.
//   MEAS  : cnt++ every cycle; fall -> fcount++.
//           5th fall (edge at 8 bit times): N = cnt value on that cycle
//           = cycles between 1st and 5th fall detect; -> DONE.
//           cnt==MAX_CNT -> FAIL.
//   DONE  : N<MIN_CNT -> FAIL; else brd<=(N<<3)>>OS_LOG2 (32-bit, truncating),
//           valid<=1, busy<=0, -> WAIT.
//   FAIL  : error<=1, busy<=0, brd unchanged, -> WAIT.
//   WAIT  : synced rx==1 -> IDLE. Start ignored here; the rest of the char is discarded.
//  Latency: valid/error pulse two cycles after the 5th fall detect cycle (MEAS->DONE->pulse).
//  valid and error are never high together; each is high exactly one cycle.
//  cnt is 32 bits, saturates at MAX_CNT, never wraps.
//  start while busy or in WAIT: ignored, no queueing.
//  start and fall in the same cycle in IDLE: start wins, fall ignored (ARM needs rx high).
//  Reset mid-measurement: immediate return to reset values, no valid/error pulse.
//  Rise edges are used only by the optional segment check.
// CONFIGURATION
//  `define UART_AUTOBAUD_SEGCHECK_EN
//   Defined: in MEAS, store first segment length s0 (fall0 -> rise1).
//    Every later segment s_i (edge to edge, 8 segments total) must satisfy |s_i - s0| <= s0>>2.
//    A violation -> FAIL at that edge, without waiting for edge 5.
//   Undefined: no segment registers or comparators; only MIN_CNT/MAX_CNT checks apply.
// TESTING
//  T1 reset: drive reset=0 two cycles -> brd=1736, busy=valid=error=0.
//  T2 0x55 @ 434 clk/bit, start pulsed while idle-high -> N=3472, valid pulse, brd=1736, busy falls.
//  T3 0x55 @ 5208 clk/bit (9600 @ 50 MHz) -> N=41664, brd=20832.
//  T4 MAX_CNT=5000; start, 1 falling edge, line held low -> error at cnt=5000, brd keeps prior value.
//  T5 0x55 @ 6 clk/bit (N=48 < 64) -> error pulse, brd unchanged. Reset mid-MEAS -> no pulse, busy=0.
//  T6 0x55, 434 clk/bit except segment 3 = 868 clk:
//     SEGCHECK_EN defined -> error at segment-3 end edge.
//     SEGCHECK_EN undefined -> valid, N=3906, brd=1953.

Source files
------------

// File: rtl/uart_autobaud.sv
// rtl/uart_autobaud.sv - autobaud measurer for a 0x55 sync char; optional UART_AUTOBAUD_SEGCHECK_EN
module uart_autobaud #(
    parameter int unsigned OS_LOG2     = 4,
    parameter int unsigned MIN_CNT     = 64,
    parameter int unsigned MAX_CNT     = 1048575,
    parameter logic [31:0] BRD_DEFAULT = 32'd1736
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    input  logic        start,
    output logic        busy,
    output logic        valid,
    output logic        error,
    output logic [31:0] brd
);
    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_HUNT, S_MEAS, S_DONE, S_FAIL, S_WAIT
    } state_t;

    localparam logic [31:0] MAX_W = 32'(MAX_CNT);
    localparam logic [31:0] MIN_W = 32'(MIN_CNT);

    state_t      state_q;
    logic        meta_q, sync_q0, sync_q1;
    logic [31:0] cnt_q, cnt_d, n_q, brd_q, brd_d;
    logic [2:0]  fcount_q;
    logic        busy_q, valid_q, error_q;
    logic        fall, seg_bad;

    assign fall  = sync_q1 & ~sync_q0;
    assign cnt_d = (cnt_q == MAX_W) ? cnt_q : cnt_q + 32'd1;
    assign brd_d = (n_q << 3) >> OS_LOG2;

`ifdef UART_AUTOBAUD_SEGCHECK_EN
    logic        rise, s0_ok_q;
    logic [31:0] s0_q, last_q, seg_len, seg_diff;

    // Every edge-to-edge segment after the first must stay within s0/4 of s0.
    assign rise     = ~sync_q1 & sync_q0;
    assign seg_len  = cnt_q - last_q;
    assign seg_diff = (seg_len > s0_q) ? seg_len - s0_q : s0_q - seg_len;
    assign seg_bad  = s0_ok_q & (fall | rise) & (seg_diff > (s0_q >> 2));
`else
    assign seg_bad  = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            meta_q   <= 1'b1;
            sync_q0  <= 1'b1;
            sync_q1  <= 1'b1;
            cnt_q    <= '0;
            n_q      <= '0;
            fcount_q <= '0;
            brd_q    <= BRD_DEFAULT;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
`ifdef UART_AUTOBAUD_SEGCHECK_EN
            s0_ok_q  <= 1'b0;
            s0_q     <= '0;
            last_q   <= '0;
`endif
        end else begin
            meta_q  <= rx;
            sync_q0 <= meta_q;
            sync_q1 <= sync_q0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    state_q <= S_ARM;
                    busy_q  <= 1'b1;
                end
                S_ARM: if (sync_q0) state_q <= S_HUNT;
                S_HUNT: if (fall) begin
                    state_q  <= S_MEAS;
                    cnt_q    <= 32'd1;
                    fcount_q <= 3'd1;
`ifdef UART_AUTOBAUD_SEGCHECK_EN
                    s0_ok_q  <= 1'b0;
                    last_q   <= '0;
`endif
                end
                S_MEAS: begin
                    cnt_q <= cnt_d;
`ifdef UART_AUTOBAUD_SEGCHECK_EN
                    if (fall | rise) begin
                        last_q <= cnt_q;
                        if (!s0_ok_q) begin
                            s0_q    <= cnt_q;
                            s0_ok_q <= 1'b1;
                        end
                    end
`endif
                    if (seg_bad) begin
                        state_q <= S_FAIL;
                    end else if (fall && fcount_q == 3'd4) begin
                        n_q     <= cnt_q;
                        state_q <= S_DONE;
                    end else if (cnt_q == MAX_W) begin
                        state_q <= S_FAIL;
                    end else if (fall) begin
                        fcount_q <= fcount_q + 3'd1;
                    end
                end
                S_DONE: begin
                    if (n_q < MIN_W) begin
                        error_q <= 1'b1;
                    end else begin
                        brd_q   <= brd_d;
                        valid_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_FAIL: begin
                    error_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: if (sync_q0) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign error = error_q;
    assign brd   = brd_q;
endmodule

// File: tb/tb_uart_autobaud.sv
// tb/tb_uart_autobaud.sv - directed self-checking bench for uart_autobaud
module tb_uart_autobaud;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1, start = 1'b0, rx2 = 1'b1, start2 = 1'b0;
    logic        busy, valid, error, busy2, valid2, error2;
    logic [31:0] brd, brd2;

    int cyc = 0;
    int n_chk = 0, n_fail = 0;
    int v_n = 0, e_n = 0, v_cyc = 0, e_cyc = 0, both_n = 0;
    int v2_n = 0, e2_n = 0, e2_cyc = 0;
    int drop_cyc = 0, drop2_cyc = 0;
    int v0, e0, v20, e20;

    uart_autobaud dut (
        .clock(clock), .reset(reset), .rx(rx), .start(start),
        .busy(busy), .valid(valid), .error(error), .brd(brd)
    );

    uart_autobaud #(.MAX_CNT(5000)) dut_to (
        .clock(clock), .reset(reset), .rx(rx2), .start(start2),
        .busy(busy2), .valid(valid2), .error(error2), .brd(brd2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (valid) begin v_n <= v_n + 1; v_cyc <= cyc; end
        if (error) begin e_n <= e_n + 1; e_cyc <= cyc; end
        if (valid && error) both_n <= both_n + 1;
        if (valid2) v2_n <= v2_n + 1;
        if (error2) begin e2_n <= e2_n + 1; e2_cyc <= cyc; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic arm();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    task automatic send_55(input int bitc, input int seg3c);
        for (int i = 0; i < 10; i++) begin
            rx = ((i % 2) == 1);
            if (i == 0) drop_cyc = cyc;
            repeat ((i == 3) ? seg3c : bitc) @(negedge clock);
        end
    endtask

    initial begin
        // T1: reset values
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("t1_brd", brd, 32'd1736);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_valid", {31'd0, valid}, 32'd0);
        chk("t1_error", {31'd0, error}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // T2: 434 clk/bit
        v0 = v_n; e0 = e_n;
        arm();
        chk("t2_busy_armed", {31'd0, busy}, 32'd1);
        send_55(434, 434);
        repeat (10) @(negedge clock);
        chk("t2_valid_cnt", v_n - v0, 1);
        chk("t2_error_cnt", e_n - e0, 0);
        chk("t2_latency", v_cyc - drop_cyc, 3476);
        chk("t2_brd", brd, 32'd1736);
        chk("t2_busy", {31'd0, busy}, 32'd0);

        // T3: 5208 clk/bit
        v0 = v_n;
        arm();
        send_55(5208, 5208);
        repeat (10) @(negedge clock);
        chk("t3_valid_cnt", v_n - v0, 1);
        chk("t3_brd", brd, 32'd20832);

        // T4: timeout on instance with MAX_CNT=5000
        v20 = v2_n; e20 = e2_n;
        start2 = 1'b1;
        @(negedge clock);
        start2 = 1'b0;
        repeat (5) @(negedge clock);
        rx2 = 1'b0;
        drop2_cyc = cyc;
        repeat (5100) @(negedge clock);
        chk("t4_error_cnt", e2_n - e20, 1);
        chk("t4_valid_cnt", v2_n - v20, 0);
        chk("t4_latency", e2_cyc - drop2_cyc, 5004);
        chk("t4_brd", brd2, 32'd1736);
        chk("t4_busy", {31'd0, busy2}, 32'd0);
        rx2 = 1'b1;
        repeat (5) @(negedge clock);

        // T5: N=48 below MIN_CNT
        v0 = v_n; e0 = e_n;
        arm();
        send_55(6, 6);
        repeat (10) @(negedge clock);
        chk("t5_error_cnt", e_n - e0, 1);
        chk("t5_valid_cnt", v_n - v0, 0);
        chk("t5_latency", e_cyc - drop_cyc, 52);
        chk("t5_brd", brd, 32'd20832);

        // T5b: reset mid-measurement
        v0 = v_n; e0 = e_n;
        arm();
        rx = 1'b0;
        repeat (100) @(negedge clock);
        chk("t5b_busy_meas", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        chk("t5b_busy", {31'd0, busy}, 32'd0);
        chk("t5b_brd", brd, 32'd1736);
        rx = 1'b1;
        repeat (20) @(negedge clock);
        chk("t5b_no_valid", v_n - v0, 0);
        chk("t5b_no_error", e_n - e0, 0);

        // T6: segment 3 stretched to 868 clk
        v0 = v_n; e0 = e_n;
        arm();
        send_55(434, 868);
        repeat (10) @(negedge clock);
`ifdef UART_AUTOBAUD_SEGCHECK_EN
        chk("t6_error_cnt", e_n - e0, 1);
        chk("t6_valid_cnt", v_n - v0, 0);
        chk("t6_latency", e_cyc - drop_cyc, 2174);
        chk("t6_brd", brd, 32'd1736);
`else
        chk("t6_valid_cnt", v_n - v0, 1);
        chk("t6_error_cnt", e_n - e0, 0);
        chk("t6_latency", v_cyc - drop_cyc, 3910);
        chk("t6_brd", brd, 32'd1953);
`endif
        chk("both_high", both_n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
